// File: rtl/count_arbiter.sv
// count_arbiter: one down-counting timer shared round-robin among R requesters.
// Optional abort on a dropped request is built in when COUNT_ARB_ABORT_EN is defined.
module count_arbiter #(
  parameter int N = 18,
  parameter int R = 4,
  localparam int W = (R > 1) ? $clog2(R) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] len,
  input  logic           tick_en,
  output logic [R-1:0]   gnt,
  output logic [R-1:0]   done,
  output logic           busy,
  output logic [W-1:0]   owner,
  output logic [N-1:0]   count
);

  // state | meaning
  // IDLE  | no grant, arbitrating pending requests
  // LOAD  | owner granted, its length loaded into the counter
  // RUN   | counting down on tick_en
  // DONE  | done[owner] pulse, grant released next cycle
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t         state_q;
  logic [R-1:0]   gnt_q;
  logic [R-1:0]   done_q;
  logic           busy_q;
  logic [W-1:0]   owner_q;
  logic [W-1:0]   ptr_q;
  logic [N-1:0]   count_q;
  logic [W-1:0]   win_d;
  logic [W-1:0]   idx;
  logic [N-1:0]   len_sel;
  logic           abort_d;

  // Walk from ptr+R down to ptr+1 so the nearest requester after ptr wins last.
  always_comb begin
    win_d = ptr_q;
    idx   = '0;
    for (int k = R; k >= 1; k--) begin
      idx = W'((int'(ptr_q) + k) % R);
      if (req[idx]) win_d = idx;
    end
  end

  assign len_sel = len[int'(owner_q)*N +: N];

`ifdef COUNT_ARB_ABORT_EN
  assign abort_d = ~req[owner_q];
`else
  assign abort_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      count_q <= '0;
      ptr_q   <= W'(R-1);
    end else begin
      done_q <= '0;
      if (abort_d && (state_q == LOAD || state_q == RUN)) begin
        state_q <= IDLE;
        gnt_q   <= '0;
        busy_q  <= 1'b0;
        count_q <= '0;
        ptr_q   <= owner_q;
      end else begin
        case (state_q)
          IDLE: begin
            if (|req) begin
              owner_q <= win_d;
              gnt_q   <= R'(1) << win_d;
              busy_q  <= 1'b1;
              state_q <= LOAD;
            end
          end
          LOAD: begin
            count_q <= len_sel;
            if (len_sel == '0) begin
              done_q  <= gnt_q;
              state_q <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
          RUN: begin
            if (tick_en && count_q != '0) begin
              count_q <= count_q - N'(1);
              if (count_q == N'(1)) begin
                done_q  <= gnt_q;
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= owner_q;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign count = count_q;

endmodule
